// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-weight fully-connected layer:
// default dimensions, the activation type, accumulator sizing and saturation.
package bnn_pkg;

    localparam int INPUT_DIM_DEF  = 16;
    localparam int OUTPUT_DIM_DEF = 8;
    localparam int BIT_WIDTH_DEF  = 8;

    typedef logic signed [BIT_WIDTH_DEF-1:0] act_t;

    // Width that holds a sum of n terms of magnitude up to 2^(bw-1),
    // including the negated most-negative input.
    function automatic int acc_width(input int bw, input int n);
        return bw + $clog2(n) + 1;
    endfunction

    // Clamp a signed value to the range of a bw-bit two's complement number.
    function automatic longint saturate(input longint acc, input int bw);
        longint max_v;
        longint min_v;
        max_v = (longint'(1) <<< (bw - 1)) - longint'(1);
        min_v = -(longint'(1) <<< (bw - 1));
        if (acc > max_v)
            return max_v;
        else if (acc < min_v)
            return min_v;
        else
            return acc;
    endfunction

endpackage

// File: rtl/bin_neuron.sv
// One binary-weight neuron: each input is added or subtracted according to
// its weight bit, and the signed terms are reduced by a balanced adder tree.
// Purely combinational; inputs beyond INPUT_DIM in the padded tree are zero.
module bin_neuron
    import bnn_pkg::*;
#(
    parameter int INPUT_DIM = INPUT_DIM_DEF,
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int ACC_W     = acc_width(BIT_WIDTH_DEF, INPUT_DIM_DEF)
) (
    input  logic [INPUT_DIM-1:0][BIT_WIDTH-1:0] value_in,
    input  logic [INPUT_DIM-1:0]                weight_row,
    output logic signed [ACC_W-1:0]             acc
);

    localparam int LEVELS = $clog2(INPUT_DIM);
    localparam int N_PAD  = 1 << LEVELS;

    genvar l, k;
    generate
        for (l = 0; l <= LEVELS; l++) begin : g_lvl
            localparam int W = N_PAD >> l;
            logic signed [ACC_W-1:0] sum [W];

            if (l == 0) begin : g_leaf
                for (k = 0; k < W; k++) begin : g_k
                    if (k < INPUT_DIM) begin : g_in
                        logic signed [ACC_W-1:0] x_ext;
                        // Sign-extend first so negating the most-negative input is exact.
                        assign x_ext  = ACC_W'($signed(value_in[k]));
                        assign sum[k] = weight_row[k] ? x_ext : -x_ext;
                    end else begin : g_pad
                        assign sum[k] = '0;
                    end
                end
            end else begin : g_add
                for (k = 0; k < W; k++) begin : g_k
                    assign sum[k] = g_lvl[l-1].sum[2*k] + g_lvl[l-1].sum[2*k+1];
                end
            end
        end
    endgenerate

    assign acc = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/proposed_model_w_bin.sv
// Fully-parallel fully-connected layer with +/-1 weights (BinaryNet style).
// Every output neuron sums its inputs combinationally, the sum is saturated
// to BIT_WIDTH and registered, giving a fixed one-cycle latency with no stall.
// Build option: define PROPOSED_MODEL_RELU_EN to clamp negative results to 0.
module proposed_model_w_bin
    import bnn_pkg::*;
#(
    parameter int INPUT_DIM  = INPUT_DIM_DEF,
    parameter int OUTPUT_DIM = OUTPUT_DIM_DEF,
    parameter int BIT_WIDTH  = BIT_WIDTH_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    input  logic [INPUT_DIM-1:0][BIT_WIDTH-1:0]   value_in,
    input  logic [OUTPUT_DIM-1:0][INPUT_DIM-1:0]  weight,
    output logic                                  out_valid,
    output logic [OUTPUT_DIM-1:0][BIT_WIDTH-1:0]  value_out
);

    localparam int ACC_W = acc_width(BIT_WIDTH, INPUT_DIM);

    logic signed [ACC_W-1:0]               acc_p0 [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0][BIT_WIDTH-1:0]  res_p0;
    logic                                  vld_p1;
    longint                                sat_v;

    genvar o;
    generate
        for (o = 0; o < OUTPUT_DIM; o++) begin : g_neuron
            bin_neuron #(
                .INPUT_DIM (INPUT_DIM),
                .BIT_WIDTH (BIT_WIDTH),
                .ACC_W     (ACC_W)
            ) u_neuron (
                .value_in   (value_in),
                .weight_row (weight[o]),
                .acc        (acc_p0[o])
            );
        end
    endgenerate

    // Saturate each accumulator to the activation range (and optionally rectify).
    always_comb begin
        res_p0 = '0;
        sat_v  = 0;
        for (int i = 0; i < OUTPUT_DIM; i++) begin
            sat_v = saturate(longint'(acc_p0[i]), BIT_WIDTH);
`ifdef PROPOSED_MODEL_RELU_EN
            if (sat_v < 0)
                sat_v = 0;
`endif
            res_p0[i] = sat_v[BIT_WIDTH-1:0];
        end
    end

    // ---- stage p0 -> p1: output register; results hold while idle ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            value_out <= '0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid)
                value_out <= res_p0;
        end
    end

    assign out_valid = vld_p1;

endmodule

// File: tb/tb_proposed_model_w_bin.sv
// Directed bench for proposed_model_w_bin with hand-computed expectations.
// Honours PROPOSED_MODEL_RELU_EN when computing negative expectations.
module tb_proposed_model_w_bin;

    localparam int IN_D  = 16;
    localparam int OUT_D = 8;
    localparam int BW    = 8;

    logic                          clk;
    logic                          rst_n;
    logic                          in_valid;
    logic [IN_D-1:0][BW-1:0]       value_in;
    logic [OUT_D-1:0][IN_D-1:0]    weight;
    logic                          out_valid;
    logic [OUT_D-1:0][BW-1:0]      value_out;

    int n_assert = 0;
    int n_fail   = 0;

    proposed_model_w_bin #(
        .INPUT_DIM  (IN_D),
        .OUTPUT_DIM (OUT_D),
        .BIT_WIDTH  (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .value_in  (value_in),
        .weight    (weight),
        .out_valid (out_valid),
        .value_out (value_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rl(input int v);
`ifdef PROPOSED_MODEL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input int exp);
        logic signed [BW-1:0] v;
        v = value_out[idx];
        chk($sformatf("%s[%0d]", tag, idx), int'(v), exp);
    endtask

    task automatic chk_all(input string tag, input int exp);
        for (int i = 0; i < OUT_D; i++)
            chk_out(tag, i, exp);
    endtask

    task automatic set_x(input int x);
        for (int i = 0; i < IN_D; i++)
            value_in[i] = 8'(x);
    endtask

    task automatic set_w(input logic [IN_D-1:0] row);
        for (int i = 0; i < OUT_D; i++)
            weight[i] = row;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        value_in = '0;
        weight   = '0;
        #23;
        chk("rst_valid", int'(out_valid), 0);
        chk_all("rst_value", 0);
        rst_n = 1'b1;
        tick();

        // all +1 weights, x=1: 16
        set_w(16'hFFFF); set_x(1); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ones_valid", int'(out_valid), 1);
        chk_all("ones", 16);
        tick();
        chk("idle_valid", int'(out_valid), 0);
        chk_all("idle_hold", 16);

        // all -1 weights, x=3: -48
        set_w(16'h0000); set_x(3); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("neg_valid", int'(out_valid), 1);
        chk_all("neg48", rl(-48));

        // alternating row 0 with x=5 cancels to 0
        set_w(16'hFFFF); weight[0] = 16'hAAAA; set_x(5); in_valid = 1'b1;
        tick();
        chk_out("alt", 0, 0);
        chk_out("alt_ones", 1, 80);

        // x[i]=i: row 1 all +1 gives 120; row 0 alternating gives 64-56=8
        for (int i = 0; i < IN_D; i++) value_in[i] = 8'(i);
        tick();
        in_valid = 1'b0;
        chk_out("ramp", 1, 120);
        chk_out("ramp_alt", 0, 8);

        // saturation corners
        set_w(16'hFFFF); set_x(127); in_valid = 1'b1;
        tick();
        chk_all("sat_hi", 127);
        set_w(16'h0000);
        tick();
        chk_all("sat_lo", rl(-128));
        set_x(-128);
        tick();
        in_valid = 1'b0;
        chk_all("sat_negmin", 127);

        // back-to-back burst
        set_w(16'hFFFF);
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_x(k);
            tick();
            chk("b2b_valid", int'(out_valid), 1);
            chk_all("b2b", 16 * k);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_valid", int'(out_valid), 0);
        chk_all("b2b_hold", 64);

        // asynchronous reset in the middle of a burst
        set_x(2); in_valid = 1'b1;
        tick();
        chk("pre_rst_valid", int'(out_valid), 1);
        chk_out("pre_rst", 3, 32);
        set_x(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk_all("async_rst", 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", int'(out_valid), 0);
        chk_all("post_rst", 0);
        tick();
        chk("post_rst_valid2", int'(out_valid), 0);
        chk_out("post_rst2", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
